ucie_ctl_rx_buffer_ctrl: RTL and testbench

Controller and storage sequencer for the UCIe RX receive buffer. It gates lane-side writes on the link state request and manages a circular buffer with occupancy tracking. It drains data to the protocol layer over a valid/ready handshake and returns one credit per freed entry. On overflow it flushes the buffer and reports the event. It sits between the RX lane deserializer and the protocol-layer consumer.

---
 rtl/ucie_ctl_rx_buffer_ctrl_pkg.sv | 16 +
 rtl/ucie_ctl_rx_buffer_ctrl_if.sv | 35 +++
 rtl/ucie_ctl_rx_buffer_ctrl_mem.sv | 26 ++
 rtl/ucie_ctl_rx_buffer_ctrl.sv | 124 ++++++++++++
 tb/tb_ucie_ctl_rx_buffer_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ucie_ctl_rx_buffer_ctrl_pkg.sv
// Shared constants for the UCIe RX buffer controller.
// State encodings are one-hot so the debug port is directly readable.
package ucie_ctl_rx_pkg;

    localparam int RX_DATA_W = 32;
    localparam int RX_DEPTH  = 8;
    localparam int RX_REQ_W  = 3;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'b0001;
    localparam state_t ST_ACTIVE   = 4'b0010;
    localparam state_t ST_DRAIN    = 4'b0100;
    localparam state_t ST_OVERFLOW = 4'b1000;

endpackage

// File: rtl/ucie_ctl_rx_buffer_ctrl_if.sv
// Lane-write, protocol-read and status bundle of the RX buffer controller.
// master drives the inputs (lane side + consumer), slave is the controller.
interface ucie_ctl_rx_buffer_ctrl_if
    import ucie_ctl_rx_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) ();

    logic [RX_REQ_W-1:0] i_state_request;
    logic                i_wr_valid;
    logic [DATA_W-1:0]   i_wr_data;
    logic                i_rd_ready;
    logic                o_rd_valid;
    logic [DATA_W-1:0]   o_rd_data;
    logic                o_credit_return;
    logic [CNT_W-1:0]    o_count;
    logic                o_buffer_enable;
    logic                o_overflow_detected;
    logic [3:0]          o_state;

    modport master (
        output i_state_request, i_wr_valid, i_wr_data, i_rd_ready,
        input  o_rd_valid, o_rd_data, o_credit_return, o_count,
        input  o_buffer_enable, o_overflow_detected, o_state
    );

    modport slave (
        input  i_state_request, i_wr_valid, i_wr_data, i_rd_ready,
        output o_rd_valid, o_rd_data, o_credit_return, o_count,
        output o_buffer_enable, o_overflow_detected, o_state
    );

endinterface

// File: rtl/ucie_ctl_rx_buffer_ctrl_mem.sv
// RX buffer storage: DEPTH x DATA_W register file, one sync write port
// and one combinational read port. The array is intentionally not reset.
module ucie_ctl_rx_buffer_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ucie_ctl_rx_buffer_ctrl.sv
// UCIe RX buffer controller: link-state gated circular buffer with
// credit return per drained entry and flush-on-overflow.
module ucie_ctl_rx_buffer_ctrl
    import ucie_ctl_rx_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    ucie_ctl_rx_buffer_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en_q;
    logic              credit_q;

    logic              req_act;
    logic              st_active;
    logic              st_drain;
    logic              st_ovf;
    logic              full;
    logic              rd_valid;
    logic              hs;
    logic              wr_acc;
    logic              ovf;
    logic [DATA_W-1:0] mem_rdata;

    assign req_act   = |bus.i_state_request;
    assign st_active = (state_q == ST_ACTIVE);
    assign st_drain  = (state_q == ST_DRAIN);
    assign st_ovf    = (state_q == ST_OVERFLOW);
    assign full      = (cnt_q == CNT_W'(DEPTH));

    assign rd_valid = (st_active || st_drain) && (cnt_q != '0);
    assign hs       = rd_valid && bus.i_rd_ready;

    // A full buffer still takes a write when a read frees a slot this cycle
    assign wr_acc = st_active && bus.i_wr_valid && (!full || hs);
    assign ovf    = st_active && bus.i_wr_valid && full && !hs;

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[0]: begin
                if (req_act) state_d = ST_ACTIVE;
            end
            state_q[1]: begin
                if (ovf)           state_d = ST_OVERFLOW;
                else if (!req_act) state_d = ST_DRAIN;
            end
            state_q[2]: begin
                if (req_act) begin
                    state_d = ST_ACTIVE;
                end else if ((cnt_q == '0) ||
                             ((cnt_q == CNT_W'(1)) && hs)) begin
                    state_d = ST_IDLE;
                end
            end
            state_q[3]: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q + AW'(wr_acc);
        rptr_d = rptr_q + AW'(hs);
        cnt_d  = cnt_q + CNT_W'(wr_acc) - CNT_W'(hs);
        // Flush: contents dropped without returning credits
        if (st_ovf) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            credit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            en_q     <= (state_d == ST_ACTIVE);
            credit_q <= hs;
        end
    end

    ucie_ctl_rx_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_acc),
        .i_waddr (wptr_q),
        .i_wdata (bus.i_wr_data),
        .i_raddr (rptr_q),
        .o_rdata (mem_rdata)
    );

    assign bus.o_rd_valid          = rd_valid;
    assign bus.o_rd_data           = rd_valid ? mem_rdata : '0;
    assign bus.o_credit_return     = credit_q;
    assign bus.o_count             = cnt_q;
    assign bus.o_buffer_enable     = en_q;
    assign bus.o_overflow_detected = st_ovf;
    assign bus.o_state             = state_q;

endmodule

// File: tb/tb_ucie_ctl_rx_buffer_ctrl.sv
// Scoreboard bench for the UCIe RX buffer controller.
module tb_ucie_ctl_rx_buffer_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_ACTIVE = 4'b0010;
    localparam logic [3:0] S_DRAIN  = 4'b0100;
    localparam logic [3:0] S_OVF    = 4'b1000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cred_cnt = 0;
    int   cred_base;
    logic prev_hs  = 1'b0;
    logic [DW-1:0] sb_q [$];

    ucie_ctl_rx_buffer_ctrl_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    ucie_ctl_rx_buffer_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop scoreboard on handshakes, check credit one cycle later
    always @(negedge clk) begin
        chk("credit", bus.o_credit_return, prev_hs);
        if (bus.o_credit_return) cred_cnt++;
        if (!rst && bus.o_rd_valid && bus.i_rd_ready) begin
            if (sb_q.size() == 0) chk("sb_empty", 1, 0);
            else                  chk("rd_data", bus.o_rd_data, sb_q.pop_front());
        end
        prev_hs = !rst && bus.o_rd_valid && bus.i_rd_ready;
    end

    task automatic wr(input logic [DW-1:0] d, input bit exp_acc);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = d;
        if (exp_acc) sb_q.push_back(d);
        tick();
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic wait_cnt0(input int lim);
        int n = 0;
        while (bus.o_count != 0 && n < lim) begin
            tick();
            n++;
        end
        chk("wait_cnt0_timeout", n < lim, 1);
    endtask

    task automatic wait_state(input logic [3:0] s, input int lim);
        int n = 0;
        while (bus.o_state != s && n < lim) begin
            tick();
            n++;
        end
        chk("wait_state_timeout", n < lim, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_state_request = '0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_ready = 1'b0;
        tick();
        tick();
        chk("rst_state", bus.o_state, S_IDLE);
        chk("rst_count", bus.o_count, 0);
        chk("rst_en", bus.o_buffer_enable, 0);
        chk("rst_rdv", bus.o_rd_valid, 0);
        chk("rst_ovf", bus.o_overflow_detected, 0);
        chk("rst_rdata", bus.o_rd_data, 0);
        rst = 1'b0;

        // IDLE ignores writes
        wr(32'hDEAD, 0);
        chk("idle_cnt", bus.o_count, 0);

        bus.i_state_request = 3'b001;
        tick();
        chk("act_state", bus.o_state, S_ACTIVE);
        chk("act_en", bus.o_buffer_enable, 1);
        chk("act_rdv", bus.o_rd_valid, 0);
        chk("act_cnt", bus.o_count, 0);

        // 5 writes, then drain
        cred_base = cred_cnt;
        for (int i = 0; i < 5; i++) wr(32'hA0 + DW'(i), 1);
        chk("cnt5", bus.o_count, 5);
        chk("rdv5", bus.o_rd_valid, 1);
        bus.i_rd_ready = 1'b1;
        wait_cnt0(20);
        bus.i_rd_ready = 1'b0;
        tick();
        chk("cred5", cred_cnt - cred_base, 5);
        chk("sb_empty5", sb_q.size(), 0);

        // Overflow on 9th write
        cred_base = cred_cnt;
        for (int i = 0; i < 8; i++) wr(32'hE0 + DW'(i), 1);
        chk("cnt8", bus.o_count, 8);
        wr(32'hEEEE, 0);
        chk("ovf_state", bus.o_state, S_OVF);
        chk("ovf_pulse", bus.o_overflow_detected, 1);
        chk("ovf_rdv", bus.o_rd_valid, 0);
        sb_q.delete();
        tick();
        chk("ovf_off", bus.o_overflow_detected, 0);
        chk("ovf_idle", bus.o_state, S_IDLE);
        chk("ovf_cnt", bus.o_count, 0);
        tick();
        chk("ovf_cred", cred_cnt - cred_base, 0);
        chk("reenter_act", bus.o_state, S_ACTIVE);

        // Full with simultaneous write+read, pointer wrap
        for (int i = 0; i < 8; i++) wr(32'hF0 + DW'(i), 1);
        chk("full_cnt", bus.o_count, 8);
        bus.i_rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr(32'h100 + DW'(i), 1);
            chk("full_ovf", bus.o_overflow_detected, 0);
            chk("full_cnt8", bus.o_count, 8);
        end
        wait_cnt0(20);
        bus.i_rd_ready = 1'b0;
        tick();
        chk("sb_empty_wrap", sb_q.size(), 0);

        // Drain with mid-drain re-request
        cred_base = cred_cnt;
        for (int i = 0; i < 3; i++) wr(32'hC0 + DW'(i), 1);
        bus.i_state_request = 3'b000;
        tick();
        chk("drain_state", bus.o_state, S_DRAIN);
        chk("drain_en", bus.o_buffer_enable, 0);
        wr(32'hD0, 0);
        chk("drain_nowr", bus.o_count, 3);
        bus.i_rd_ready = 1'b1;
        tick();
        bus.i_rd_ready = 1'b0;
        bus.i_state_request = 3'b100;
        tick();
        chk("rereq_state", bus.o_state, S_ACTIVE);
        chk("rereq_cnt", bus.o_count, 2);
        bus.i_state_request = 3'b000;
        tick();
        bus.i_rd_ready = 1'b1;
        wait_state(S_IDLE, 20);
        chk("drain_cnt0", bus.o_count, 0);
        bus.i_rd_ready = 1'b0;
        tick();
        chk("drain_cred", cred_cnt - cred_base, 3);
        chk("drain_sb", sb_q.size(), 0);

        // Mid-operation reset with 4 entries
        bus.i_state_request = 3'b010;
        wait_state(S_ACTIVE, 5);
        cred_base = cred_cnt;
        for (int i = 0; i < 4; i++) wr(32'h55 + DW'(i), 1);
        chk("pre_rst_cnt", bus.o_count, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_state_request = 3'b000;
        sb_q.delete();
        chk("mrst_state", bus.o_state, S_IDLE);
        chk("mrst_cnt", bus.o_count, 0);
        chk("mrst_en", bus.o_buffer_enable, 0);
        chk("mrst_rdv", bus.o_rd_valid, 0);
        chk("mrst_rdata", bus.o_rd_data, 0);
        chk("mrst_credit", bus.o_credit_return, 0);
        tick();
        tick();
        chk("mrst_cred", cred_cnt - cred_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
